// File: rtl/cla_nibble_serial_ctrl.sv
// Nibble-serial WIDTH-bit adder built around one shared 4-bit carry-lookahead slice.
// Latency: out_valid rises WIDTH/4 cycles after the accept edge; one accept per WIDTH/4+2 cycles at best.
// Backpressure: result is held in DONE until out_ready; in_ready is low while busy. Optional macro: CLA_SUB_EN.
module cla_nibble_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              carry;
  logic              sub_q;
  logic              cin_eff;
  logic [3:0]        a_nib, b_nib, g, p, sum_nib;
  logic [4:0]        c;

`ifdef CLA_SUB_EN
  // Subtraction forces the carry-in to 1 so that A + ~B + 1 = A - B.
  assign cin_eff = in_sub ? 1'b1 : in_cin;
`else
  assign cin_eff = in_cin;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept, walk N nibbles, hold the result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = RUN;
      RUN:     if (idx == LAST)     state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Select the current operand nibbles; B is inverted for subtraction.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDXW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
    if (sub_q) b_nib = ~b_nib;
  end

  // 4-bit carry-lookahead slice: every carry is computed directly from g, p and the chained carry.
  always_comb begin
    g    = a_nib & b_nib;
    p    = a_nib ^ b_nib;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum_nib = p ^ c[3:0];
  end

  // Datapath: capture operands on accept, then write one result nibble per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      sub_q    <= 1'b0;
      idx      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_q   <= in_a;
        b_q   <= in_b;
        carry <= cin_eff;
        idx   <= '0;
`ifdef CLA_SUB_EN
        sub_q <= in_sub;
`else
        sub_q <= 1'b0;
`endif
      end
    end else if (state == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (idx == IDXW'(i)) out_sum[4*i +: 4] <= sum_nib;
      end
      carry <= c[4];
      if (idx == LAST) out_cout <= c[4];
      else             idx      <= idx + IDXW'(1);
    end
  end

endmodule

// File: tb/tb_cla_nibble_serial_ctrl.sv
module tb_cla_nibble_serial_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid = 0, out_ready = 0, in_cin = 0;
  logic [15:0] in_a = 0, in_b = 0;
  logic        in_ready, out_valid, out_cout, busy;
  logic [15:0] out_sum;
`ifdef CLA_SUB_EN
  logic        in_sub = 0;
  logic        in_sub4 = 0;
`endif

  // 4-bit instance
  logic        in_valid4 = 0, out_ready4 = 0, in_cin4 = 0;
  logic [3:0]  in_a4 = 0, in_b4 = 0;
  logic        in_ready4, out_valid4, out_cout4, busy4;
  logic [3:0]  out_sum4;

  cla_nibble_serial_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef CLA_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .busy(busy)
  );

  cla_nibble_serial_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
`ifdef CLA_SUB_EN
    .in_sub(in_sub4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4),
    .out_cout(out_cout4), .busy(busy4)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec16_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
  } vec4_t;

  // One full transaction on the 16-bit instance with latency and handshake checks.
  task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [15:0] es, input logic ec);
    int lat;
    @(negedge clk);
    check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd4);
    check({name, " sum"}, 32'(out_sum), 32'(es));
    check({name, " cout"}, 32'(out_cout), 32'(ec));
    check({name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid after take"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run4(input string name, input logic [3:0] a, input logic [3:0] b,
                      input logic cin, input logic [3:0] es, input logic ec);
    int lat;
    @(negedge clk);
    in_a4 = a; in_b4 = b; in_cin4 = cin; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd1);
    check({name, " sum"}, 32'(out_sum4), 32'(es));
    check({name, " cout"}, 32'(out_cout4), 32'(ec));
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  vec16_t v16[7];
  vec4_t  v4[3];

  initial begin
    logic [15:0] held_sum;
    logic        held_cout;
    int          unstable;
    int          extra;
    int          lat;

    v16[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    v16[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    v16[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    v16[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    v16[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    v16[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    v16[6] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
    v4[0]  = '{4'h9, 4'h8, 1'b1, 4'h2, 1'b1};
    v4[1]  = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0};
    v4[2]  = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};

    // Reset state
    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_sum", 32'(out_sum), 32'd0);
    check("reset out_cout", 32'(out_cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run16($sformatf("vec16[%0d]", i), v16[i].a, v16[i].b, v16[i].cin, v16[i].sum, v16[i].cout);
    for (int i = 0; i < 3; i++)
      run4($sformatf("vec4[%0d]", i), v4[i].a, v4[i].b, v4[i].cin, v4[i].sum, v4[i].cout);

    // Back-pressure, busy, and in_valid ignored mid-RUN
    @(negedge clk);
    in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp busy in RUN", 32'(busy), 32'd1);
    @(negedge clk);
    in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_a = 16'h0F0F; in_b = 16'h7777;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp out_valid reached", 32'(out_valid), 32'd1);
    held_sum = out_sum;
    held_cout = out_cout;
    check("bp sum", 32'(held_sum), 32'h5555);
    check("bp cout", 32'(held_cout), 32'd0);
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!out_valid || out_sum !== held_sum || out_cout !== held_cout || !busy) unstable++;
    end
    check("bp held stable 10 cycles", 32'(unstable), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid || !in_ready) extra++;
    end
    check("bp no second result", 32'(extra), 32'd0);

    // Reset mid-operation at idx=2
    @(negedge clk);
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst out_sum", 32'(out_sum), 32'd0);
    check("midrst out_cout", 32'(out_cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run16("after reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

`ifdef CLA_SUB_EN
    in_sub = 1'b1;
    run16("sub 5-7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    run16("sub 7-5", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    in_sub = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
